// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals of the two-port ALU arbiter.
interface alu_arbiter_if #(parameter int XLEN = 32);
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]      req0_control, req1_control;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [2:0]      alu_control;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [XLEN-1:0] rsp_result;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_control,
    input  req1_valid, req1_a, req1_b, req1_control,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_control,
    output rsp_valid, rsp_result, rsp_id
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_control,
    output req1_valid, req1_a, req1_b, req1_control,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_control,
    input  rsp_valid, rsp_result, rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a single registered result slot that can refill in the same cycle it drains.
module alu_arbiter #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic last_grant, grant, any, free, accept;
  always_comb begin
    any = bus.req0_valid | bus.req1_valid;
    grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    // reset gating keeps both readies low while the async reset is held
    free = ~reset & ((state == EMPTY) | bus.rsp_ready);
    accept = any & free;
    state_n = accept ? FULL : bus.rsp_ready ? EMPTY : state;
    bus.req0_ready = accept & ~grant;
    bus.req1_ready = accept & grant;
    bus.alu_a = ~any ? '0 : grant ? bus.req1_a : bus.req0_a;
    bus.alu_b = ~any ? '0 : grant ? bus.req1_b : bus.req0_b;
    bus.alu_control = ~any ? 3'b000 : grant ? bus.req1_control : bus.req0_control;
    bus.rsp_valid = state == FULL;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.rsp_result <= '0;
      bus.rsp_id <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      bus.rsp_result <= bus.alu_result;
      bus.rsp_id <= grant;
      last_grant <= grant;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed scoreboard bench; the shared ALU is modelled here.
module tb_alu_arbiter;
  localparam int XLEN = 32;
  logic clk = 0, reset = 1;
  int n_checks = 0, n_fail = 0;
  alu_arbiter_if #(XLEN) bus();
  alu_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_fn(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[$clog2(XLEN)-1:0];
      3'd6: return a >> b[$clog2(XLEN)-1:0];
      default: return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
    endcase
  endfunction
  assign bus.alu_result = alu_fn(bus.alu_control, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most one pending {id,result} and the last granted id.
  logic [XLEN:0] exp_q[$];
  logic m_last = 1'b1;

  function automatic logic m_grant();
    return (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
  endfunction
  function automatic logic m_free();
    return !reset && (exp_q.size() == 0 || bus.rsp_ready);
  endfunction

  always @(negedge clk) begin
    logic g, any, acc;
    g = m_grant();
    any = bus.req0_valid || bus.req1_valid;
    acc = any && m_free();
    chk("rsp_valid", bus.rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("rsp_result", bus.rsp_result, exp_q[0][XLEN-1:0]);
      chk("rsp_id", bus.rsp_id, exp_q[0][XLEN]);
    end
    chk("req0_ready", bus.req0_ready, acc && !g);
    chk("req1_ready", bus.req1_ready, acc && g);
    chk("alu_a", bus.alu_a, !any ? '0 : g ? bus.req1_a : bus.req0_a);
    chk("alu_b", bus.alu_b, !any ? '0 : g ? bus.req1_b : bus.req0_b);
    chk("alu_control", bus.alu_control, !any ? 3'd0 : g ? bus.req1_control : bus.req0_control);
  end

  always @(posedge clk) begin
    logic g;
    if (reset) begin
      exp_q.delete();
      m_last = 1'b1;
    end else begin
      g = m_grant();
      if (exp_q.size() != 0 && bus.rsp_ready) void'(exp_q.pop_front());
      if ((bus.req0_valid || bus.req1_valid) && (exp_q.size() == 0 || bus.rsp_ready || 1'b0)) begin
        exp_q.push_back(g ? {1'b1, alu_fn(bus.req1_control, bus.req1_a, bus.req1_b)}
                          : {1'b0, alu_fn(bus.req0_control, bus.req0_a, bus.req0_b)});
        m_last = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.req0_valid = 0; bus.req1_valid = 0;
  endtask
  task automatic set0(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req0_valid = 1; bus.req0_control = op; bus.req0_a = a; bus.req0_b = b;
  endtask
  task automatic set1(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req1_valid = 1; bus.req1_control = op; bus.req1_a = a; bus.req1_b = b;
  endtask
  task automatic do_reset();
    reset = 1;
    exp_q.delete();
    m_last = 1'b1;
    #1;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_req0_ready", bus.req0_ready, 0);
    chk("reset_req1_ready", bus.req1_ready, 0);
    tick();
    reset = 0;
  endtask

  initial begin
    idle();
    bus.req0_a = 0; bus.req0_b = 0; bus.req0_control = 0;
    bus.req1_a = 0; bus.req1_b = 0; bus.req1_control = 0;
    bus.rsp_ready = 1;
    #2;
    do_reset();
    // single ADD
    set0(3'd0, 124, 73);
    @(negedge clk) chk("add_req0_ready", bus.req0_ready, 1);
    tick(); idle();
    @(negedge clk);
    chk("add_result", bus.rsp_result, 197);
    chk("add_id", bus.rsp_id, 0);
    chk("add_valid", bus.rsp_valid, 1);
    tick(); tick();
    // both valid after reset: req0 first
    do_reset();
    set0(3'd1, 124, 73); set1(3'd4, 124, 73);
    tick(); idle(); bus.req1_valid = 1;
    @(negedge clk);
    chk("sub_result", bus.rsp_result, 51);
    chk("sub_id", bus.rsp_id, 0);
    tick(); idle();
    @(negedge clk);
    chk("xor_result", bus.rsp_result, 53);
    chk("xor_id", bus.rsp_id, 1);
    tick(); tick();
    // sustained alternation
    do_reset();
    set0(3'd0, 5, 6); set1(3'd3, 9, 2);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) idle();
      @(negedge clk);
      chk("alt_id", bus.rsp_id, i % 2);
      chk("alt_valid", bus.rsp_valid, 1);
    end
    tick(); tick();
    // held result under backpressure
    set1(3'd5, 1, 4);
    bus.rsp_ready = 0;
    tick(); set0(3'd0, 3, 3); bus.req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_result", bus.rsp_result, 16);
      chk("hold_id", bus.rsp_id, 1);
      chk("hold_req0_ready", bus.req0_ready, 0);
      chk("hold_req1_ready", bus.req1_ready, 0);
      tick();
    end
    idle(); bus.rsp_ready = 1;
    tick();
    @(negedge clk) chk("drain_valid", bus.rsp_valid, 0);
    // reset while full
    tick();
    set0(3'd0, 124, 73); bus.rsp_ready = 0;
    tick(); idle();
    @(negedge clk);
    chk("pre_reset_result", bus.rsp_result, 197);
    #2;
    do_reset();
    bus.rsp_ready = 1;
    set0(3'd2, 12, 10); set1(3'd6, 64, 2);
    tick(); idle();
    @(negedge clk) chk("post_reset_id", bus.rsp_id, 0);
    tick(); tick();
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.req0_valid = $urandom_range(0, 2) != 0;
      bus.req1_valid = $urandom_range(0, 2) != 0;
      bus.req0_control = 3'($urandom); bus.req1_control = 3'($urandom);
      bus.req0_a = $urandom; bus.req0_b = $urandom;
      bus.req1_a = $urandom; bus.req1_b = $urandom;
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    idle(); bus.rsp_ready = 1;
    tick(); tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
